// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_pkg
// Brief    : Shared defaults, counter width and helpers for the LED driver.
// Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int unsigned HALF_PERIOD_DEFAULT = 25_000_000;
    localparam int unsigned PWM_BITS_DEFAULT    = 8;
    localparam int unsigned CNT_W               = 32;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Duty-step interval: half-period spread over 2^bits steps, never below 1.
    function automatic int unsigned calc_step(input int unsigned hp, input int unsigned bits);
        int unsigned s;
        s = hp >> bits;
        return (s > 0) ? s : 1;
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_tick_gen
// Brief    : Free-running modulo-PERIOD counter with a one-cycle wrap tick.
// Revision : 1.0 - initial release
// ============================================================================
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned PERIOD = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Tick is high during the cycle whose closing edge wraps the counter.
    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + ONE;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led.sv
`default_nettype none
// ============================================================================
// Module   : led
// Brief    : LED driver. Blinks at 2*HALF_PERIOD cycles by default; defining
//            LED_BREATHE_EN swaps in a PWM "breathing" ramp instead.
// Revision : 1.0 - initial release
// ============================================================================
module led
    import led_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEFAULT,
    parameter int unsigned PWM_BITS    = PWM_BITS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic ledout
);

    if (HALF_PERIOD < 2) begin : g_bad_half_period
        $error("led: HALF_PERIOD must be >= 2");
    end

    if ((PWM_BITS < 4) || (PWM_BITS > 12)) begin : g_bad_pwm_bits
        $error("led: PWM_BITS must be in 4..12");
    end

    logic ledout_d;
    logic ledout_q;

    assign ledout = ledout_q;

`ifndef LED_BREATHE_EN

    logic half_tick;

    led_tick_gen #(
        .PERIOD (HALF_PERIOD)
    ) u_half_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (half_tick)
    );

    always_comb begin
        ledout_d = ledout_q;
        if (half_tick) begin
            ledout_d = ~ledout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ledout_q <= 1'b0;
        end else begin
            ledout_q <= ledout_d;
        end
    end

`else

    localparam int unsigned         STEP     = calc_step(HALF_PERIOD, PWM_BITS);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    logic                step_tick;
    logic [PWM_BITS-1:0] pwm_cnt_d, pwm_cnt_q;
    logic [PWM_BITS-1:0] target_d,  target_q;
    logic [PWM_BITS-1:0] duty_d,    duty_q;
    dir_e                dir_d,     dir_q;

    led_tick_gen #(
        .PERIOD (STEP)
    ) u_step_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (step_tick)
    );

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_ONE;
        target_d  = target_q;
        dir_d     = dir_q;
        duty_d    = duty_q;

        // Direction flips on the step that lands on an end value, so each
        // end value is produced exactly once per sweep.
        if (step_tick) begin
            if (dir_q == DIR_UP) begin
                target_d = target_q + PWM_ONE;
                if (target_q == (DUTY_MAX - PWM_ONE)) begin
                    dir_d = DIR_DOWN;
                end
            end else begin
                target_d = target_q - PWM_ONE;
                if (target_q == PWM_ONE) begin
                    dir_d = DIR_UP;
                end
            end
        end

        // The ramp runs independently; a frame only sees it at its start.
        if (pwm_cnt_q == DUTY_MAX) begin
            duty_d = target_q;
        end

        ledout_d = (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pwm_cnt_q <= '0;
            target_q  <= '0;
            duty_q    <= '0;
            dir_q     <= DIR_UP;
            ledout_q  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            target_q  <= target_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            ledout_q  <= ledout_d;
        end
    end

`endif

endmodule : led
`default_nettype wire

// File: tb/tb_led.sv
`default_nettype none
// ============================================================================
// Module   : tb_led
// Brief    : Scoreboard bench for led; blink mode by default, breathing mode
//            when LED_BREATHE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    always #5 clk = ~clk;

`ifndef LED_BREATHE_EN

    logic led5, led8, led2;

    led #(.HALF_PERIOD(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .ledout(led5));
    led #(.HALF_PERIOD(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .ledout(led8));
    led #(.HALF_PERIOD(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .ledout(led2));

    typedef struct {
        logic        e5;
        logic        e8;
        logic        e2;
        int unsigned n;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_rel;

    // After n edges out of reset the LED has completed floor(n/hp) half-periods.
    function automatic logic model(input int unsigned n, input int unsigned hp);
        return ((n / hp) % 2) == 1;
    endfunction

    task automatic drive(input logic r);
        exp_t e;
        rst_n = r;
        if (r) n_rel = 0;
        else   n_rel = n_rel + 1;
        e.e5 = model(n_rel, 5);
        e.e8 = model(n_rel, 8);
        e.e2 = model(n_rel, 2);
        e.n  = n_rel;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic act, input logic exp, input int unsigned n);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: ledout=%b expected=%b edges_since_release=%0d", name, act, exp, n);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                if (!done) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: queue empty, expected an entry");
                end
            end else begin
                e = sb.pop_front();
                check("blink_hp5", led5, e.e5, e.n);
                check("blink_hp8", led8, e.e8, e.n);
                check("blink_hp2", led2, e.e2, e.n);
            end
        end
    end

    initial begin : stimulus
        n_rel = 0;
        drive(1'b1);
        repeat (49) begin @(negedge clk); drive(1'b1); end
        repeat (200) begin @(negedge clk); drive(1'b0); end
        // Park HP=8 at cnt=5 with the LED lit, then pulse reset once.
        while ((n_rel % 16) != 13) begin @(negedge clk); drive(1'b0); end
        @(negedge clk); drive(1'b1);
        repeat (40) begin @(negedge clk); drive(1'b0); end
        repeat (30) begin
            repeat ($urandom_range(1, 40)) begin @(negedge clk); drive(1'b0); end
            repeat ($urandom_range(1, 3))  begin @(negedge clk); drive(1'b1); end
        end
        repeat (30) begin @(negedge clk); drive(1'b0); end
        @(negedge clk);
        done = 1'b1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

`else

    logic led_b;
    int   exp_q[$];
    bit   mon_run = 1'b0;

    led #(.HALF_PERIOD(64), .PWM_BITS(4)) u_dut (.clk(clk), .rst_n(rst_n), .ledout(led_b));

    // Ramp position k: 0,1..15 then 14..1, repeating every 30 steps.
    function automatic int tri_duty(input int k);
        int r;
        r = k % 30;
        return (r <= 15) ? r : 30 - r;
    endfunction

    initial begin : monitor
        int highs;
        int smp;
        int e;
        highs = 0;
        smp   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_run) begin
                highs = highs + int'(led_b);
                smp   = smp + 1;
                if (smp == 16) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_underflow: high_count=%0d, no expected entry", highs);
                    end else begin
                        e = exp_q.pop_front();
                        if (highs != e) begin
                            bad++;
                            $display("FAIL frame_high_count: got=%0d expected=%0d", highs, e);
                        end
                    end
                    smp   = 0;
                    highs = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int frames;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            total++;
            if (led_b !== 1'b0) begin
                bad++;
                $display("FAIL reset_ledout: got=%b expected=0", led_b);
            end
        end
        frames  = $urandom_range(60, 90);
        rst_n   = 1'b0;
        mon_run = 1'b1;
        for (int m = 0; m < frames; m++) begin
            exp_q.push_back((m == 0) ? 0 : tri_duty(4 * m - 1));
            repeat (16) @(negedge clk);
        end
        done = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

`endif

endmodule : tb_led
`default_nettype wire
